error_poly_reader: RTL
======================

// Module: error_poly_reader
// PURPOSE
// - Read side of the sampled-polynomial memories filled by the random sampler (v, e0, e1).
// - Reads the coefficients of one selected polynomial in address order and lifts each one to a residue mod q.
// - Delivers the residues as a valid/ready stream to the encryption datapath (NTT / pointwise-multiply input).
// PARAMETERS
// LOGN  13  log2 of max ring degree; memory address width
// LOGQ  54  residue width
// M     17  width of qm field of q
// W     24  width of low zero field of q
// PORTS
// clk          in   1     clock
// rst_n        in   1     asynchronous active-low reset
// start        in   1     one-cycle pulse; accepted only when busy=0
// poly_sel     in   2     sampling_pkg::poly_sel_t: 0=V, 1=E0, 2=E1 (3 reserved, start ignored)
// current_n    in   2     degree select: N = 2^(LOGN-2+current_n); 3 treated as 2
// current_k    in   4     q top-field select (0..8)
// qm           in   M     q middle field
// rd_addr      out  LOGN  shared read address to v/e0/e1 memories
// rd_en_v      out  1     read enable, v memory
// rd_en_e0     out  1     read enable, e0 memory
// rd_en_e1     out  1     read enable, e1 memory
// rd_data_v    in   2     v data, valid 1 cycle after rd_en_v
// rd_data_e0   in   6     e0 data (sign-magnitude), valid 1 cycle after rd_en_e0
// rd_data_e1   in   6     e1 data (sign-magnitude), valid 1 cycle after rd_en_e1
// coeff_data   out  LOGQ  residue in [0,q)
// coeff_valid  out  1     coeff_data valid
// coeff_ready  in   1     sink accepts when valid&ready
// coeff_last   out  1     marks coefficient N-1
// busy         out  1     high from start acceptance until last coefficient handed off
// done         out  1     one-cycle pulse the cycle after the last handshake
// BEHAVIOUR
// - Reset values: rd_addr=0, all rd_en=0, coeff_valid=0, coeff_last=0, coeff_data=0, busy=0, done=0; FIFO emptied, FSM=IDLE.
// - FSM IDLE -> RUN on accepted start. In RUN: reads are issued; moves to DRAIN after address N-1 is issued. DRAIN -> IDLE on the coeff_last handshake (done=1 that cycle+1).
// - q_DP, poly_sel_DP and N are latched at start, so input changes while busy have no effect.
//   q = {13'h1fff>>(8-current_k), qm, (W-1)'0, 1'b1}.
// - Read issue: one address per cycle while (fifo_count + in_flight) < 4. Only the selected memory's rd_en is asserted.
// - Pipeline: issue (cycle t) -> memory data (t+1) -> registered conversion (t+2) -> FIFO write.
//   First coeff_valid occurs 3 cycles after the start cycle. Throughput is 1/cycle with ready held high.
// - Conversion, e0/e1: mag=d[4:0]. Sign d[5]=0 -> mag; d[5]=1 & mag!=0 -> q-mag; d[5]=1 & mag=0 -> 0.
// - Conversion, v: 0->0, 1->1, 3->q-1, 2->0.
// - All arithmetic is LOGQ bits; mag is zero-extended; no wrap can occur since mag<q.
// - FIFO: 4-entry with head registered onto coeff_data. coeff_valid stays high and data stays stable until ready.
//   Full blocks issue (no overflow, no loss). Empty deasserts valid.
// - coeff_last travels with the data of address N-1. rd_addr wraps to 0 after the last read.
// - start while busy is ignored. start coincident with done: the start is accepted, because busy is already low in that cycle.
// - rst_n low mid-operation: immediate return to reset values; in-flight reads are discarded.
// CONFIGURATION
// - ERR_BOUND_CHECK_EN defined: adds output err_flag (1 bit, reset 0).
//   Sticky-set on e0/e1 magnitude >21 or v code 2. Cleared on accepted start.
//   Out-of-range data is still converted as specified above.
// - Undefined: no err_flag port and no check logic.
// STRUCTURE
// - sampling_pkg: poly_sel_t enum, FIFO_DEPTH=4, CBD_MAX_MAG=21, function build_q(k,qm) shared with the sampler's q construction.
// - Sub-module coeff_fifo (parameterised width/depth, registered head) holds the output buffer.
// - Read FSM, credit counter and conversion stay in error_poly_reader.
// TESTING
// - LOGN=4, current_n=2, E0 mem = addr-derived +/-mag, ready=1 -> 16 residues in order, first valid at start+3, coeff_last on #15, done pulse next cycle.
// - V mem {0,1,3,2}, k=8, qm=1 -> residues {0,1,q-1,0}; with ERR_BOUND_CHECK_EN, err_flag=1 after 4th read.
// - e1 word 6'b100000 (-0) -> 0; 6'b100001 -> q-1; 6'b010101 -> 21.
// - ready toggles 1-of-3 cycles, random -> no drop/duplicate vs golden model, data stable while valid&!ready, rd_en never issued with 4 credits used.
// - current_n=0 -> exactly 4 coefficients (LOGN=4); start pulsed mid-run ignored; start on done cycle begins a second run.
// - rst_n asserted at coefficient 5 -> all outputs 0 asynchronously; new start restarts from rd_addr=0.

Source files
------------

// File: rtl/sampling_pkg.sv
// Shared definitions for the sampled-polynomial memories and their readers.
// Holds the polynomial selector encoding, buffer depth, CBD magnitude bound
// and the q construction used by both the sampler and the reader.
package sampling_pkg;

    typedef enum logic [1:0] {
        POLY_V    = 2'd0,
        POLY_E0   = 2'd1,
        POLY_E1   = 2'd2,
        POLY_RSVD = 2'd3
    } poly_sel_t;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_RUN   = 2'd1,
        RD_DRAIN = 2'd2
    } reader_state_t;

    localparam int FIFO_DEPTH  = 4;
    localparam int CBD_MAX_MAG = 21;

    localparam int Q_LOGQ = 54;
    localparam int Q_M    = 17;
    localparam int Q_W    = 24;
    localparam int Q_TOP  = Q_LOGQ - Q_M - Q_W;

    // q = {top ones field, qm, zeros, 1}; the top field holds 5+k ones.
    function automatic logic [Q_LOGQ-1:0] build_q(input logic [3:0] k,
                                                  input logic [Q_M-1:0] qm);
        logic [Q_TOP-1:0] top;
        top = 13'h1fff >> (4'd8 - k);
        return {top, qm, {(Q_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/coeff_fifo.sv
// Small shift-register FIFO whose head entry is always a flop, so the
// consumer sees registered data. Writes land just behind the current tail.
module coeff_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] ent_q [DEPTH];
    logic [WIDTH-1:0] ent_d [DEPTH];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    wr_idx;
    logic             do_pop, do_push;

    // Shift out the head on pop and place a new entry at the first free slot.
    always_comb begin
        ent_d   = ent_q;
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q < CW'(DEPTH)) || do_pop);
        wr_idx  = do_pop ? (cnt_q - CW'(1)) : cnt_q;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                ent_d[i] = ent_q[i+1];
            end
        end
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == wr_idx) begin
                    ent_d[i] = push_data_i;
                end
            end
        end
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Storage and occupancy registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = ent_q[0];
    assign valid_o = (cnt_q != '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/error_poly_reader.sv
// Reads one sampled polynomial (v, e0 or e1) in address order, lifts each
// coefficient to a residue mod q and streams it out over valid/ready.
// Optional ERR_BOUND_CHECK_EN adds a sticky err_flag for out-of-range words.
module error_poly_reader
    import sampling_pkg::*;
#(
    parameter int LOGN = 13,
    parameter int LOGQ = Q_LOGQ,
    parameter int M    = Q_M,
    parameter int W    = Q_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      poly_sel,
    input  logic [1:0]      current_n,
    input  logic [3:0]      current_k,
    input  logic [M-1:0]    qm,
    output logic [LOGN-1:0] rd_addr,
    output logic            rd_en_v,
    output logic            rd_en_e0,
    output logic            rd_en_e1,
    input  logic [1:0]      rd_data_v,
    input  logic [5:0]      rd_data_e0,
    input  logic [5:0]      rd_data_e1,
    output logic [LOGQ-1:0] coeff_data,
    output logic            coeff_valid,
    input  logic            coeff_ready,
    output logic            coeff_last,
    output logic            busy,
    output logic            done
`ifdef ERR_BOUND_CHECK_EN
    ,
    output logic            err_flag
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    reader_state_t   state_q, state_d;
    logic [LOGN-1:0] addr_q, addr_d;
    logic [LOGN-1:0] last_q, last_d;
    logic [LOGQ-1:0] q_q, q_d;
    poly_sel_t       sel_q, sel_d;
    logic            pend_q, pend_d;
    logic            pend_last_q, pend_last_d;
    logic            done_q, done_d;

    logic            start_ok, issue, hs, hs_last;
    logic [1:0]      n_sel;
    logic [5:0]      e_word;
    logic [LOGQ-1:0] mag, conv;
    logic [LOGQ:0]   fifo_head;
    logic            fifo_valid;
    logic [CW-1:0]   fifo_cnt;

    assign start_ok = start && (state_q == RD_IDLE) && (poly_sel != 2'd3);
    assign n_sel    = (current_n == 2'd3) ? 2'd2 : current_n;
    assign issue    = (state_q == RD_RUN) &&
                      ((int'(fifo_cnt) + int'(pend_q)) < FIFO_DEPTH);
    assign hs       = fifo_valid && coeff_ready;
    assign hs_last  = hs && fifo_head[LOGQ];

    // Next-state logic: latch the job on start, walk addresses, drain on last.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_d      = last_q;
        q_d         = q_q;
        sel_d       = sel_q;
        pend_d      = issue;
        pend_last_d = issue && (addr_q == last_q);
        done_d      = hs_last;
        case (state_q)
            RD_IDLE: begin
                if (start_ok) begin
                    state_d = RD_RUN;
                    addr_d  = '0;
                    last_d  = {LOGN{1'b1}} >> (2'd2 - n_sel);
                    q_d     = build_q(current_k, qm);
                    sel_d   = poly_sel_t'(poly_sel);
                end
            end
            RD_RUN: begin
                if (issue) begin
                    if (addr_q == last_q) begin
                        addr_d  = '0;
                        state_d = RD_DRAIN;
                    end else begin
                        addr_d = addr_q + LOGN'(1);
                    end
                end
            end
            RD_DRAIN: begin
                if (hs_last) begin
                    state_d = RD_IDLE;
                end
            end
            default: state_d = RD_IDLE;
        endcase
    end

    // Control and job registers; in-flight reads are dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RD_IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            q_q         <= '0;
            sel_q       <= POLY_V;
            pend_q      <= 1'b0;
            pend_last_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_q      <= last_d;
            q_q         <= q_d;
            sel_q       <= sel_d;
            pend_q      <= pend_d;
            pend_last_q <= pend_last_d;
            done_q      <= done_d;
        end
    end

    // Lift the returned memory word to a residue in [0,q).
    always_comb begin
        e_word = (sel_q == POLY_E1) ? rd_data_e1 : rd_data_e0;
        mag    = {{(LOGQ-5){1'b0}}, e_word[4:0]};
        conv   = '0;
        case (sel_q)
            POLY_V: begin
                case (rd_data_v)
                    2'd1:    conv = LOGQ'(1);
                    2'd3:    conv = q_q - LOGQ'(1);
                    default: conv = '0;
                endcase
            end
            POLY_E0, POLY_E1: begin
                if (!e_word[5]) begin
                    conv = mag;
                end else if (mag != '0) begin
                    conv = q_q - mag;
                end else begin
                    conv = '0;
                end
            end
            default: conv = '0;
        endcase
    end

    coeff_fifo #(
        .WIDTH (LOGQ + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .push_i      (pend_q),
        .push_data_i ({pend_last_q, conv}),
        .pop_i       (hs),
        .head_o      (fifo_head),
        .valid_o     (fifo_valid),
        .count_o     (fifo_cnt)
    );

    assign rd_addr     = addr_q;
    assign rd_en_v     = issue && (sel_q == POLY_V);
    assign rd_en_e0    = issue && (sel_q == POLY_E0);
    assign rd_en_e1    = issue && (sel_q == POLY_E1);
    assign coeff_data  = fifo_head[LOGQ-1:0];
    assign coeff_valid = fifo_valid;
    assign coeff_last  = fifo_valid && fifo_head[LOGQ];
    assign busy        = (state_q != RD_IDLE);
    assign done        = done_q;

`ifdef ERR_BOUND_CHECK_EN
    logic err_q, err_d, bad_word;

    // Sticky range flag: cleared by a new job, set by any out-of-range word.
    always_comb begin
        bad_word = 1'b0;
        if (pend_q) begin
            if (sel_q == POLY_V) begin
                bad_word = (rd_data_v == 2'd2);
            end else begin
                bad_word = (e_word[4:0] > 5'(CBD_MAX_MAG));
            end
        end
        err_d = err_q;
        if (start_ok) begin
            err_d = 1'b0;
        end
        if (bad_word) begin
            err_d = 1'b1;
        end
    end

    // Range flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_flag = err_q;
`endif

endmodule
